// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO built from a register array, wrap-around
// read/write pointers and an occupancy counter.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset (pointers, count, outputs)
//   data_in      write data
//   wr_en        write request
//   rd_en        read request
//   data_out     read data, registered, one-cycle latency; holds when idle
//   wr_ack       registered: write accepted on the previous edge
//   overflow     registered: write rejected on the previous edge (full)
//   underflow    registered: read rejected on the previous edge (empty)
//   full         count == FIFO_DEPTH
//   almostfull   count == FIFO_DEPTH-1
//   empty        count == 0
//   almostempty  count == 1
//   count        current occupancy
module sync_fifo_ctrl #(
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [FIFO_WIDTH-1:0]         data_in,
   input  logic                          wr_en,
   input  logic                          rd_en,
   output logic [FIFO_WIDTH-1:0]         data_out,
   output logic                          wr_ack,
   output logic                          overflow,
   output logic                          underflow,
   output logic                          full,
   output logic                          almostfull,
   output logic                          empty,
   output logic                          almostempty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;

   // Status flags come straight from the occupancy counter.
   always_comb begin
      full        = (count == CNT_W'(FIFO_DEPTH));
      almostfull  = (count == CNT_W'(FIFO_DEPTH - 1));
      empty       = (count == '0);
      almostempty = (count == CNT_W'(1));
   end

   // A write into a full FIFO is still taken when a read frees a slot on the same edge.
   always_comb begin
      wr_acc = wr_en & (~full | rd_en);
      rd_acc = rd_en & ~empty;
   end

   // Storage array; intentionally not reset, empty gates every read.
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Write pointer with explicit wrap so non-power-of-two depths work.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
      end else if (wr_acc) begin
         if (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) begin
            wr_ptr <= '0;
         end else begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
      end
   end

   // Read pointer and registered read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         data_out <= '0;
      end else if (rd_acc) begin
         data_out <= mem[rd_ptr];
         if (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) begin
            rd_ptr <= '0;
         end else begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Occupancy: a simultaneous accepted read and write cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Handshake and error strobes, each describing the previous edge's request.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         wr_ack    <= wr_acc;
         overflow  <= wr_en & full & ~rd_en;
         underflow <= rd_en & empty;
      end
   end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: directed steps followed by a random
// phase, all checked against a queue-based reference model.
module tb_sync_fifo_ctrl;

   localparam int unsigned W  = 16;
   localparam int unsigned D  = 8;
   localparam int unsigned CW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  data_in;
   logic          wr_en;
   logic          rd_en;
   logic [W-1:0]  data_out;
   logic          wr_ack;
   logic          overflow;
   logic          underflow;
   logic          full;
   logic          almostfull;
   logic          empty;
   logic          almostempty;
   logic [CW-1:0] count;

   sync_fifo_ctrl #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .data_out    (data_out),
      .wr_ack      (wr_ack),
      .overflow    (overflow),
      .underflow   (underflow),
      .full        (full),
      .almostfull  (almostfull),
      .empty       (empty),
      .almostempty (almostempty),
      .count       (count)
   );

   always #5 clk = ~clk;

   // Reference model: contents as a queue, registered outputs as plain variables.
   logic [W-1:0] q [$];
   logic [W-1:0] exp_dout;
   logic         exp_ack;
   logic         exp_ovf;
   logic         exp_udf;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("count",       32'(count),       32'(n));
      chk("empty",       32'(empty),       32'(n == 0));
      chk("almostempty", 32'(almostempty), 32'(n == 1));
      chk("almostfull",  32'(almostfull),  32'(n == D - 1));
      chk("full",        32'(full),        32'(n == D));
      chk("wr_ack",      32'(wr_ack),      32'(exp_ack));
      chk("overflow",    32'(overflow),    32'(exp_ovf));
      chk("underflow",   32'(underflow),   32'(exp_udf));
      chk("data_out",    32'(data_out),    32'(exp_dout));
   endtask

   // Apply one cycle of inputs, advance the model on pre-edge occupancy, then check.
   task automatic step(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
      bit was_full;
      bit was_empty;
      rst     = r;
      wr_en   = w;
      rd_en   = rd;
      data_in = d;
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      if (r) begin
         q.delete();
         exp_dout = '0;
         exp_ack  = 1'b0;
         exp_ovf  = 1'b0;
         exp_udf  = 1'b0;
      end else begin
         exp_ack = w && (!was_full || rd);
         exp_ovf = w && was_full && !rd;
         exp_udf = rd && was_empty;
         if (rd && !was_empty) exp_dout = q.pop_front();
         if (exp_ack) q.push_back(d);
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      logic w;
      logic r;
      exp_dout = '0;
      exp_ack  = 1'b0;
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;

      // Reset with both requests high; reset must win.
      step(1'b1, 1'b1, 1'b1, 16'h1234);
      step(1'b1, 1'b1, 1'b1, 16'h1234);

      // Fill to full.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, W'(16'hA000 + i));

      // Two rejected writes while full.
      step(1'b0, 1'b1, 1'b0, 16'hDEAD);
      step(1'b0, 1'b1, 1'b0, 16'hDEAD);

      // Simultaneous read and write at full.
      step(1'b0, 1'b1, 1'b1, 16'hBEEF);

      // Drain; 0xBEEF must come out last.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 16'h0000);

      // Underflow alone, then underflow with a write that must still land.
      step(1'b0, 1'b0, 1'b1, 16'h0000);
      step(1'b0, 1'b1, 1'b1, 16'h5555);
      step(1'b0, 1'b0, 1'b1, 16'h0000);

      // Interleaved traffic across pointer wrap, occupancy kept within 1..7.
      step(1'b0, 1'b1, 1'b0, 16'h7000);
      for (int i = 0; i < 20; i++) begin
         w = (q.size() < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
         r = (q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         step(1'b0, w, r, W'($urandom));
      end

      // Bring occupancy to 5 and reset mid-stream.
      while (q.size() > 5) step(1'b0, 1'b0, 1'b1, 16'h0000);
      while (q.size() < 5) step(1'b0, 1'b1, 1'b0, W'($urandom));
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 16'hC0DE);
      step(1'b0, 1'b0, 1'b1, 16'h0000);

      // Random traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), W'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Synchronous single-clock FIFO with registered handshake/status outputs; this is the design-under-test whose interface signals the FIFO monitor samples each negedge. It buffers FIFO_WIDTH-bit words from a producer, returns them in order on read, and reports occupancy, almost-full/almost-empty, write acknowledge, overflow and underflow. Storage is a register array indexed by wrap-around read/write pointers plus an occupancy counter.

Parameters:
FIFO_WIDTH, 16, data word width in bits
FIFO_DEPTH, 8, number of storage entries (>=4; need not be a power of 2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
data_in  input  FIFO_WIDTH  write data
wr_en  input  1  write request
rd_en  input  1  read request
data_out  output  FIFO_WIDTH  read data, registered
wr_ack  output  1  registered; previous-cycle write accepted
overflow  output  1  registered; previous-cycle write rejected (full)
underflow  output  1  registered; previous-cycle read rejected (empty)
full  output  1  combinational, count == FIFO_DEPTH
almostfull  output  1  combinational, count == FIFO_DEPTH-1
empty  output  1  combinational, count == 0
almostempty  output  1  combinational, count == 1
count  output  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset: synchronous, active-high. At a posedge with rst=1, set wr_ptr=0, rd_ptr=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0; memory is not cleared. Result: empty=1, full=almostfull=almostempty=0. Reset overrides wr_en/rd_en in that cycle. A reset mid-stream discards all stored data.
- Accept decisions use pre-edge state: wr_acc = wr_en & (~full | rd_en); rd_acc = rd_en & ~empty.
- Write: if wr_acc, mem[wr_ptr] <= data_in, wr_ptr advances (FIFO_DEPTH-1 wraps to 0), wr_ack <= 1. Otherwise wr_ack <= 0.
- overflow <= wr_en & full & ~rd_en. Asserts for exactly one cycle per rejected write.
- Read: if rd_acc, data_out <= mem[rd_ptr] and rd_ptr advances with wrap. Otherwise data_out holds its value. Read latency is 1 cycle.
- underflow <= rd_en & empty. A read while empty is rejected even when wr_en is set; the simultaneous write is still accepted.
- count: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither. It never exceeds FIFO_DEPTH and never wraps below 0.
- Full with wr_en and rd_en both set: the read drains the oldest word, the write lands in the freed slot, count stays FIFO_DEPTH, wr_ack=1, overflow=0.
- Empty with wr_en and rd_en both set: the write is accepted, count becomes 1, data_out holds, underflow=1, wr_ack=1.
- Status flags derive only from count, so they update in the same cycle count changes.
- Pointers are $clog2(FIFO_DEPTH) bits with explicit compare-and-wrap; there are no X-propagating reads of unwritten entries after reset, because empty blocks reads.

Test Plan:
- Reset check: rst=1 for 2 cycles with wr_en=rd_en=1 -> count=0, empty=1, wr_ack=overflow=underflow=0, data_out=0.
- Fill/drain, DEPTH=8: write 0xA000..0xA007 -> wr_ack=1 each cycle; almostfull at count=7; full at 8. Then read 8 times -> data_out=0xA000..0xA007 in order, one cycle after each rd_en; almostempty at count=1; empty at 0.
- Overflow: with full, wr_en=1 and rd_en=0 for 2 cycles -> overflow=1 on both following cycles, wr_ack=0, count stays 8, contents unchanged.
- Underflow: with empty, rd_en=1 -> underflow=1 next cycle, data_out keeps its last value. Same with wr_en=1 and data_in=0x5555 -> underflow=1, wr_ack=1, count=1.
- Simultaneous at full: wr_en=rd_en=1, data_in=0xBEEF -> data_out=oldest word, count=8, wr_ack=1, overflow=0. After 8 further reads, 0xBEEF emerges last.
- Wrap-around and mid-stream reset: 20 cycles of interleaved write/read keeping count between 1 and 7 -> order preserved across pointer wrap. Then rst=1 with count=5 -> next cycle count=0 and empty=1; a subsequent write/read returns the new data, not stale entries.
